wptr_full_level: RTL

- Parametrised write-side pointer, full and fill-level generator for the async FIFO. One wclk domain.
- Contains its own N-stage synchroniser for the read-domain Gray pointer.
- Beyond plain full, adds registered fill level, programmable almost-full and a sticky overflow flag.
- Sits between the write-side client and the dual-port FIFO memory, paired with the read-side pointer block.

---
 rtl/fifo_ptr_pkg.sv | 47 ++++
 rtl/gray2bin_sync.sv | 55 +++++
 rtl/wptr_full_level.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fifo_ptr_pkg.sv
// ---------------------------------------------------------------------------
// fifo_ptr_pkg
//
// Shared helpers for the async FIFO pointer blocks (write side and read side).
//
// Contents:
//   depth(addrsize)  - number of FIFO entries for a given address width
//   ptrw(addrsize)   - pointer width (one extra wrap bit above the address)
//   bin2gray(b)      - binary -> reflected Gray code
//   gray2bin(g)      - reflected Gray code -> binary
//
// The conversion functions work on a fixed MAX_PTRW-bit vector. Callers
// zero-extend their narrower pointer in and size-cast the result back out;
// the zero upper bits do not disturb the conversion of the lower bits, so
// one function body serves every pointer width up to MAX_PTRW.
// ---------------------------------------------------------------------------
package fifo_ptr_pkg;

  localparam int MAX_PTRW = 32;

  typedef logic [MAX_PTRW-1:0] ptr_word_t;

  // Number of storage entries addressed by an ADDRSIZE-bit address.
  function automatic int depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  // Pointer width: address bits plus the wrap bit that tells full from empty.
  function automatic int ptrw(input int addrsize);
    return addrsize + 1;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return (b >> 1) ^ b;
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above its position.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[MAX_PTRW-1] = g[MAX_PTRW-1];
    for (int i = MAX_PTRW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_sync.sv
// ---------------------------------------------------------------------------
// gray2bin_sync
//
// Brings a Gray-coded pointer from a foreign clock domain into the local one
// through a SYNC_STAGES-deep flop chain, then converts the synchronised value
// to binary. Shared by the write-side and read-side pointer blocks.
//
// Ports:
//   clk     in   local clock
//   rst     in   synchronous, active-high reset (clears the whole chain)
//   d_gray  in   WIDTH   Gray pointer from the other domain (asynchronous)
//   q_gray  out  WIDTH   synchronised Gray pointer (last chain stage)
//   q_bin   out  WIDTH   binary form of q_gray (combinational from q_gray)
//
// Only a Gray-coded source may pass through here: with at most one bit
// changing per source clock, a metastable capture resolves to either the old
// or the new pointer, never to an unrelated value.
// ---------------------------------------------------------------------------
module gray2bin_sync
  import fifo_ptr_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_gray,
  output logic [WIDTH-1:0] q_gray,
  output logic [WIDTH-1:0] q_bin
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  // NOTE: every chain stage is reset, even though it is written like an
  // array; after reset the consumer must see pointer 0, not a stale value
  // still rippling through the stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, so the chain shifts by exactly one per edge.
      sync_q[0] <= d_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_gray = sync_q[SYNC_STAGES-1];
  assign q_bin  = WIDTH'(gray2bin(ptr_word_t'(q_gray)));

endmodule

// File: rtl/wptr_full_level.sv
// ---------------------------------------------------------------------------
// wptr_full_level
//
// Write-side pointer, full flag and fill-level generator for the async FIFO.
// Runs entirely in the wclk domain; the read pointer arrives in Gray code and
// is synchronised internally.
//
// Ports:
//   wclk          in   write clock
//   wrst          in   synchronous, active-high reset
//   winc          in   write request; accepted only while wfull=0
//   rptr_gray     in   ADDRSIZE+1  read pointer (Gray) from the read domain
//   af_thresh     in   ADDRSIZE+1  almost-full threshold in entries
//   ovf_clr       in   clear for the sticky overflow flag
//   waddr         out  ADDRSIZE    memory write address
//   wptr          out  ADDRSIZE+1  write pointer (Gray) to the read domain
//   wfull         out  FIFO full
//   walmost_full  out  registered fill level >= af_thresh
//   wlevel        out  ADDRSIZE+1  registered fill level, 0..DEPTH
//   wovf          out  sticky: a write was attempted while full
//
// All flags are computed from the next-state pointer and registered, so they
// change on the same edge that accepts the write. The synchronised read
// pointer lags the real one, so wlevel may over-estimate the fill level for
// SYNC_STAGES edges after a read, never under-estimate it.
// ---------------------------------------------------------------------------
module wptr_full_level
  import fifo_ptr_pkg::*;
#(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr_gray,
  input  logic [ADDRSIZE:0]   af_thresh,
  input  logic                ovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam int PTRW = ptrw(ADDRSIZE);

  typedef logic [PTRW-1:0] ptr_t;

  ptr_t wbin;         // binary write pointer, including wrap bit
  ptr_t wq_rptr;      // read pointer (Gray) after synchronisation
  ptr_t rbin_sync;    // binary form of wq_rptr
  ptr_t wbinnext;
  ptr_t wgraynext;
  ptr_t levelnext;
  ptr_t full_gray;    // Gray value wptr would hold if exactly DEPTH ahead
  logic wfullnext;
  logic walmost_fullnext;
  logic wovfnext;

  gray2bin_sync #(
    .WIDTH       (PTRW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk    (wclk),
    .rst    (wrst),
    .d_gray (rptr_gray),
    .q_gray (wq_rptr),
    .q_bin  (rbin_sync)
  );

  // NOTE: every signal driven here gets a value on every path (defaults
  // first), so the block stays purely combinational and infers no latches.
  always_comb begin
    wbinnext         = wbin;
    wgraynext        = '0;
    levelnext        = '0;
    full_gray        = '0;
    wfullnext        = 1'b0;
    walmost_fullnext = 1'b0;
    wovfnext         = wovf;

    if (winc && !wfull) begin
      wbinnext = wbin + ptr_t'(1);
    end
    wgraynext = ptr_t'(bin2gray(ptr_word_t'(wbinnext)));

    // Modulo subtraction: the wrap bit makes the difference come out right
    // even when the write pointer has wrapped and the read pointer has not.
    levelnext = wbinnext - rbin_sync;

    // In Gray code, "DEPTH entries ahead" means the top two bits inverted and
    // the rest equal; comparing Gray values avoids a second subtractor on the
    // critical full path.
    full_gray = {~wq_rptr[PTRW-1:PTRW-2], wq_rptr[PTRW-3:0]};
    wfullnext = (wgraynext == full_gray);

    walmost_fullnext = (levelnext >= af_thresh);

    // Set takes priority so an overflow in the same cycle as a clear is kept.
    if (winc && wfull) begin
      wovfnext = 1'b1;
    end else if (ovf_clr) begin
      wovfnext = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wlevel       <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wovf         <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wlevel       <= levelnext;
      wfull        <= wfullnext;
      walmost_full <= walmost_fullnext;
      wovf         <= wovfnext;
    end
  end

  // Memory writes use the address present before the accepting edge.
  assign waddr = wbin[ADDRSIZE-1:0];

endmodule
